// File: rtl/div_pkg.sv
// Shared types and constants for the sequential restoring divider.
package div_pkg;

  localparam int DEFAULT_WIDTH = 4;

  // Wide enough for any practical WIDTH; sliced down at the point of use.
  localparam logic [63:0] DBZ_QUOT = '1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    FIX  = 2'd2,
    DONE = 2'd3
  } state_e;

endpackage

// File: rtl/seq_divider_if.sv
// Start/done handshake and operand/result bus between the sequencer and the divider.
interface seq_divider_if #(parameter int WIDTH = div_pkg::DEFAULT_WIDTH);

  logic             start;
  logic [WIDTH-1:0] dividend;
  logic [WIDTH-1:0] divisor;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] quotient;
  logic [WIDTH-1:0] remainder;
  logic             div_by_zero;

  modport master (
    output start, dividend, divisor,
    input  busy, done, quotient, remainder, div_by_zero
  );

  modport slave (
    input  start, dividend, divisor,
    output busy, done, quotient, remainder, div_by_zero
  );

endinterface

// File: rtl/seq_divider_trial_sub.sv
// One trial-subtraction stage: a - b as a + ~b + 1, carry-out high means no borrow.
module trial_sub #(
  parameter int W = 5
) (
  input  logic [W-1:0] a_i,
  input  logic [W-1:0] b_i,
  output logic [W-1:0] diff_o,
  output logic         cout_o
);

  logic [W-1:0] b_inv;

  assign b_inv = b_i ^ {W{1'b1}};
  assign {cout_o, diff_o} = {1'b0, a_i} + {1'b0, b_inv} + {{W{1'b0}}, 1'b1};

endmodule

// File: rtl/seq_divider.sv
// Multi-cycle restoring divider with start/done handshake.
// Define SIGNED_DIV_EN for two's-complement operands (adds the FIX sign-correction state).
module seq_divider
  import div_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic          clk,
  input  logic          rst_n,
  seq_divider_if.slave  bus
);

  localparam int CNT_W = $clog2(WIDTH + 1);

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   count_q, count_d;
  logic [WIDTH:0]     r_q, r_d;
  logic [WIDTH-1:0]   q_q, q_d;
  logic [WIDTH-1:0]   dvsr_q, dvsr_d;
  logic [WIDTH-1:0]   quot_q, quot_d;
  logic [WIDTH-1:0]   rem_q, rem_d;
  logic               dbz_q, dbz_d;

  logic [2*WIDTH:0]   rq_sh;
  logic [WIDTH:0]     r_sh;
  logic [WIDTH-1:0]   q_sh;
  logic [WIDTH:0]     t_diff;
  logic               t_cout;
  logic [WIDTH-1:0]   dvd_mag;
  logic [WIDTH-1:0]   dvs_mag;

  assign rq_sh = {r_q, q_q} << 1;
  assign r_sh  = rq_sh[2*WIDTH:WIDTH];
  assign q_sh  = rq_sh[WIDTH-1:0];

  trial_sub #(.W(WIDTH + 1)) u_trial_sub (
    .a_i    (r_sh),
    .b_i    ({1'b0, dvsr_q}),
    .diff_o (t_diff),
    .cout_o (t_cout)
  );

`ifdef SIGNED_DIV_EN
  logic neg_quot_q, neg_quot_d;
  logic neg_rem_q, neg_rem_d;

  assign dvd_mag = bus.dividend[WIDTH-1] ? -bus.dividend : bus.dividend;
  assign dvs_mag = bus.divisor[WIDTH-1]  ? -bus.divisor  : bus.divisor;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      neg_quot_q <= 1'b0;
      neg_rem_q  <= 1'b0;
    end else begin
      neg_quot_q <= neg_quot_d;
      neg_rem_q  <= neg_rem_d;
    end
  end
`else
  assign dvd_mag = bus.dividend;
  assign dvs_mag = bus.divisor;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      count_q <= '0;
      r_q     <= '0;
      q_q     <= '0;
      dvsr_q  <= '0;
      quot_q  <= '0;
      rem_q   <= '0;
      dbz_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      r_q     <= r_d;
      q_q     <= q_d;
      dvsr_q  <= dvsr_d;
      quot_q  <= quot_d;
      rem_q   <= rem_d;
      dbz_q   <= dbz_d;
    end
  end

  always_comb begin
    state_d = state_q;
    count_d = count_q;
    r_d     = r_q;
    q_d     = q_q;
    dvsr_d  = dvsr_q;
    quot_d  = quot_q;
    rem_d   = rem_q;
    dbz_d   = dbz_q;
`ifdef SIGNED_DIV_EN
    neg_quot_d = neg_quot_q;
    neg_rem_d  = neg_rem_q;
`endif

    case (state_q)
      IDLE: begin
        if (bus.start) begin
          dbz_d = 1'b0;
          if (bus.divisor == '0) begin
            quot_d  = DBZ_QUOT[WIDTH-1:0];
            rem_d   = bus.dividend;
            dbz_d   = 1'b1;
            state_d = DONE;
          end else begin
            r_d     = '0;
            q_d     = dvd_mag;
            dvsr_d  = dvs_mag;
            count_d = CNT_W'(WIDTH);
            state_d = CALC;
`ifdef SIGNED_DIV_EN
            neg_quot_d = bus.dividend[WIDTH-1] ^ bus.divisor[WIDTH-1];
            neg_rem_d  = bus.dividend[WIDTH-1];
`endif
          end
        end
      end

      CALC: begin
        // Keep the difference only when the subtraction did not borrow.
        r_d     = t_cout ? t_diff : r_sh;
        q_d     = q_sh | {{(WIDTH-1){1'b0}}, t_cout};
        count_d = count_q - 1'b1;
        if (count_q == CNT_W'(1)) begin
`ifdef SIGNED_DIV_EN
          state_d = FIX;
`else
          quot_d  = q_d;
          rem_d   = r_d[WIDTH-1:0];
          state_d = DONE;
`endif
        end
      end

`ifdef SIGNED_DIV_EN
      FIX: begin
        // Truncating division: remainder follows the dividend's sign.
        quot_d  = neg_quot_q ? -q_q : q_q;
        rem_d   = neg_rem_q ? -r_q[WIDTH-1:0] : r_q[WIDTH-1:0];
        state_d = DONE;
      end
`endif

      DONE: state_d = IDLE;

      default: state_d = IDLE;
    endcase
  end

  assign bus.busy        = (state_q == CALC) || (state_q == FIX);
  assign bus.done        = (state_q == DONE);
  assign bus.quotient    = quot_q;
  assign bus.remainder   = rem_q;
  assign bus.div_by_zero = dbz_q;

endmodule

// File: tb/tb_seq_divider.sv
// Directed and exhaustive bench for seq_divider; results are scoreboarded against a reference model.
module tb_seq_divider;
  import div_pkg::*;

  localparam int W = 4;
`ifdef SIGNED_DIV_EN
  localparam int LAT = W + 2;
`else
  localparam int LAT = W + 1;
`endif

  typedef struct packed {
    logic [W-1:0] q;
    logic [W-1:0] r;
    logic         dbz;
  } res_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  seq_divider_if #(.WIDTH(W)) bus ();

  seq_divider #(.WIDTH(W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  res_t sb[$];
  int   n_total = 0;
  int   n_pass  = 0;
  int   n_fail  = 0;
  int   n_done  = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) begin
      n_pass++;
    end else begin
      n_fail++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic res_t mk(input logic [W-1:0] q, input logic [W-1:0] r, input logic d);
    res_t x;
    x.q = q;
    x.r = r;
    x.dbz = d;
    return x;
  endfunction

  function automatic res_t ref_div(input logic [W-1:0] a, input logic [W-1:0] b);
    res_t x;
    int   qi;
    int   ri;
    if (b == '0) begin
      x.q = '1;
      x.r = a;
      x.dbz = 1'b1;
    end else begin
`ifdef SIGNED_DIV_EN
      qi = int'($signed(a)) / int'($signed(b));
      ri = int'($signed(a)) % int'($signed(b));
`else
      qi = int'(a) / int'(b);
      ri = int'(a) % int'(b);
`endif
      x.q = qi[W-1:0];
      x.r = ri[W-1:0];
      x.dbz = 1'b0;
    end
    return x;
  endfunction

  // Scoreboard side: every done pulse retires one expected result.
  always @(negedge clk) begin
    if (bus.done === 1'b1) begin
      res_t e;
      n_done++;
      check("sb_nonempty", 32'(sb.size() != 0), 32'd1);
      if (sb.size() != 0) begin
        e = sb.pop_front();
        check("quotient", 32'(bus.quotient), 32'(e.q));
        check("remainder", 32'(bus.remainder), 32'(e.r));
        check("div_by_zero", 32'(bus.div_by_zero), 32'(e.dbz));
      end
    end
  end

  // Called at a falling edge with the DUT idle; returns at a falling edge with the DUT idle again.
  task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b, input res_t exp,
                        input int lat, input logic glitch);
    int k;
    bus.start = 1'b1;
    bus.dividend = a;
    bus.divisor = b;
    sb.push_back(exp);
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    bus.dividend = W'($urandom);
    bus.divisor = W'($urandom);
    k = 0;
    while (k < 20) begin
      @(negedge clk);
      k++;
      if (k == 1 && b != '0) check("dbz_cleared", 32'(bus.div_by_zero), 32'd0);
      if (glitch && k == 2) begin
        bus.start = 1'b1;
        bus.dividend = 4'd9;
        bus.divisor = 4'd2;
      end
      if (glitch && k == 3) bus.start = 1'b0;
      if (bus.done === 1'b1) break;
      check("busy_during_op", 32'(bus.busy), 32'd1);
    end
    check("done_latency", 32'(k), 32'(lat));
    check("busy_at_done", 32'(bus.busy), 32'd0);
    @(negedge clk);
    check("done_single_pulse", 32'(bus.done), 32'd0);
  endtask

  initial begin
    int done_snap;
    bus.start = 1'b0;
    bus.dividend = '0;
    bus.divisor = '0;
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    check("rst_busy", 32'(bus.busy), 32'd0);
    check("rst_done", 32'(bus.done), 32'd0);
    check("rst_quotient", 32'(bus.quotient), 32'd0);
    check("rst_remainder", 32'(bus.remainder), 32'd0);
    check("rst_dbz", 32'(bus.div_by_zero), 32'd0);
    rst_n = 1'b1;
    @(negedge clk);

`ifdef SIGNED_DIV_EN
    run_op(4'h9, 4'h2, mk(4'hD, 4'hF, 1'b0), LAT, 1'b0);
    run_op(4'h8, 4'hF, mk(4'h8, 4'h0, 1'b0), LAT, 1'b0);
    run_op(4'h7, 4'h0, mk(4'hF, 4'h7, 1'b1), 1, 1'b0);
    run_op(4'h5, 4'h2, mk(4'h2, 4'h1, 1'b0), LAT, 1'b0);
`else
    run_op(4'd13, 4'd3, mk(4'd4, 4'd1, 1'b0), LAT, 1'b0);
    run_op(4'd15, 4'd1, mk(4'd15, 4'd0, 1'b0), LAT, 1'b0);
    run_op(4'd5, 4'd7, mk(4'd0, 4'd5, 1'b0), LAT, 1'b0);
    run_op(4'd0, 4'd9, mk(4'd0, 4'd0, 1'b0), LAT, 1'b0);
    run_op(4'd7, 4'd0, mk(4'hF, 4'd7, 1'b1), 1, 1'b0);
    run_op(4'd12, 4'd5, mk(4'd2, 4'd2, 1'b0), LAT, 1'b0);
    run_op(4'd13, 4'd3, mk(4'd4, 4'd1, 1'b0), LAT, 1'b1);
    run_op(4'd9, 4'd2, mk(4'd4, 4'd1, 1'b0), LAT, 1'b0);
`endif

    for (int a = 0; a < 16; a++) begin
      for (int b = 0; b < 16; b++) begin
        run_op(W'(a), W'(b), ref_div(W'(a), W'(b)), (b == 0) ? 1 : LAT, 1'b0);
      end
    end

    // Abort an operation with reset partway through.
    done_snap = n_done;
    bus.start = 1'b1;
    bus.dividend = 4'd13;
    bus.divisor = 4'd3;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("abort_busy", 32'(bus.busy), 32'd0);
    check("abort_done", 32'(bus.done), 32'd0);
    check("abort_quotient", 32'(bus.quotient), 32'd0);
    check("abort_remainder", 32'(bus.remainder), 32'd0);
    check("abort_dbz", 32'(bus.div_by_zero), 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (8) @(negedge clk);
    check("abort_no_done", 32'(n_done), 32'(done_snap));
    run_op(4'd12, 4'd5, ref_div(4'd12, 4'd5), LAT, 1'b0);

    repeat (2) @(negedge clk);
    check("sb_drained", 32'(sb.size()), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

endmodule
